fetch_prefetch_queue: RTL and testbench

//  Instruction prefetch FIFO between the fetch stage (ROM read) and the decode stage.

---
 rtl/fetch_prefetch_queue.sv | 99 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// fetch_prefetch_queue: {pc, instr} prefetch FIFO between fetch and decode, emptied on a redirect.
// Define PREFETCH_BYPASS_EN to let an empty queue forward the fetch word to decode in the same cycle.
module fetch_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [PC_W-1:0]            i_pc,
  input  logic [INSTR_W-1:0]         i_instr,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [PC_W-1:0]            o_pc,
  output logic [INSTR_W-1:0]         o_instr,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic has_entry;
  logic push;
  logic pop;
  logic bypass_take;

  assign has_entry = (count != '0);
  assign o_ready   = (count != FULL_COUNT);
  assign o_count   = count;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;

  // Only an empty queue forwards, so the stored head always takes precedence.
  assign bypass      = ~has_entry & i_valid & ~i_flush;
  assign bypass_take = bypass & i_ready;
  assign o_valid     = has_entry | bypass;

  always_comb begin
    o_pc    = '0;
    o_instr = '0;
    if (has_entry) begin
      o_pc    = pc_mem[rd_ptr];
      o_instr = instr_mem[rd_ptr];
    end else if (bypass) begin
      o_pc    = i_pc;
      o_instr = i_instr;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign o_valid     = has_entry;
  assign o_pc        = has_entry ? pc_mem[rd_ptr]    : '0;
  assign o_instr     = has_entry ? instr_mem[rd_ptr] : '0;
`endif

  // A word consumed straight through the bypass is never written.
  assign push = i_valid & o_ready & ~i_flush & ~bypass_take;
  assign pop  = has_entry & i_ready & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= i_pc;
      instr_mem[wr_ptr] <= i_instr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// Bench for fetch_prefetch_queue: vector table plus corner sequences, checked against a queue model.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready_in;
  logic [31:0] pc, instr;
  logic        ready_out, valid_out;
  logic [31:0] pc_out, instr_out;
  logic [2:0]  count_out;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (valid),
    .i_pc    (pc),
    .i_instr (instr),
    .o_ready (ready_out),
    .o_valid (valid_out),
    .o_pc    (pc_out),
    .o_instr (instr_out),
    .i_ready (ready_in),
    .o_count (count_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic        rd;
    logic [31:0] pc;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[12];
  int     total = 0;
  int     bad   = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] p);
    return 32'h1300_0013 ^ (p << 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance the model.
  task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                       input logic [31:0] p);
    logic   exp_r, exp_v, byp;
    entry_t head;
    rst_n = r; flush = f; valid = v; ready_in = rd; pc = p; instr = mk_instr(p);
    #3;
    byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp = v && !f && (sb.size() == 0);
`endif
    exp_r = (sb.size() != DEPTH);
    exp_v = (sb.size() != 0) || byp;
    if (r) begin
      if (sb.size() != 0)  head = sb[0];
      else if (byp)        head = '{p, mk_instr(p)};
      else                 head = '{32'h0, 32'h0};
      check("ready", 32'(ready_out), 32'(exp_r));
      check("valid", 32'(valid_out), 32'(exp_v));
      check("count", 32'(count_out), 32'(sb.size()));
      check("head_pc", pc_out, head.pc);
      check("head_instr", instr_out, head.instr);
    end
    if (!r || f) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && rd) void'(sb.pop_front());
      if (v && exp_r && !(byp && rd)) sb.push_back('{p, mk_instr(p)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready_in = 1'b0; pc = '0; instr = '0;

    // Reset with valid held high, fill past full, then drain and poll empty.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h99, 3'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h98, 3'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h00, 3'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h04, 3'd2, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h08, 3'd3, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 3'd4, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h10, 3'd4, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd3, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd2, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd0, 1'b1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst_n, 1'b0, vecs[i].v, vecs[i].rd, vecs[i].pc);
      check($sformatf("vec%0d_count", i), 32'(count_out), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ready", i), 32'(ready_out), 32'(vecs[i].exp_ready));
`ifndef PREFETCH_BYPASS_EN
      if (i == 1) begin
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_instr", instr_out, 32'h0);
      end
`endif
    end

    // Wrap: simultaneous push and pop, head lags the pushed pc by one cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, (i != 0), 32'(4 * i));
      check($sformatf("wrap%0d_count", i), 32'(count_out), 32'd1);
      check($sformatf("wrap%0d_pc", i), pc_out, 32'(4 * i));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    check("wrap_drained", 32'(count_out), 32'd0);

    // Flush with a same-cycle push, then refill.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h30);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h34);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h38);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
    check("flush_valid", 32'(valid_out), 32'h0);
    check("flush_count", 32'(count_out), 32'h0);
    check("flush_instr", instr_out, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h44);
    check("after_flush_pc", pc_out, 32'h44);
    check("after_flush_valid", 32'(valid_out), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    // Full with pop: push refused this cycle, accepted on the next.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h50);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h54);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h58);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h5C);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h60);
    check("fullpop_count", 32'(count_out), 32'd3);
    check("fullpop_head", pc_out, 32'h54);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h64);
    check("refill_count", 32'(count_out), 32'd4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    check("drain_count", 32'(count_out), 32'd0);

    // Reset mid-operation together with flush.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h70);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h74);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h78);
    check("midreset_count", 32'(count_out), 32'd0);
    check("midreset_ready", 32'(ready_out), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef PREFETCH_BYPASS_EN
    rst_n = 1'b1; flush = 1'b0; valid = 1'b1; ready_in = 1'b1;
    pc = 32'h88; instr = 32'h2002_0005;
    #3;
    check("bypass_valid", 32'(valid_out), 32'h1);
    check("bypass_instr", instr_out, 32'h2002_0005);
    check("bypass_pc", pc_out, 32'h88);
    @(posedge clk);
    #1;
    valid = 1'b0; ready_in = 1'b0;
    check("bypass_count", 32'(count_out), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
